// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seg7 scan display.
// Provides the hex segment table, segment bit indices and clog2.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Active-high g..a patterns, entry 15 first.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b1110001, 7'b1111001, 7'b1011110, 7'b1011000,
      7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
      7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
      7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
   };

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1)
         r++;
      return r;
   endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// User-side and pin-side signal bundle of the scan display.
// slave: driver view (inputs load/value/dp/blank_lz/enable, outputs pins).
interface seg7_scan_display_if #(
   parameter int DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp;
   logic                  blank_lz;
   logic                  enable;
   logic [6:0]            seg;
   logic                  seg_dp;
   logic [DIGITS-1:0]     digit_en;
   logic                  frame_done;

   modport master (
      output load, value, dp, blank_lz, enable,
      input  seg, seg_dp, digit_en, frame_done
   );

   modport slave (
      input  load, value, dp, blank_lz, enable,
      output seg, seg_dp, digit_en, frame_done
   );
endinterface

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-high 7-segment pattern (bit0=a .. bit6=g).
// Ports: nibble in (4), seg out (7).
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed multi-digit 7-segment driver with frame-synced update.
// Ports: clock, reset_n, bus (slave: load/value/dp/blank_lz/enable -> pins).
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int PRESCALE       = 12000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   seg7_scan_display_if.slave bus
);
   localparam int PW = clog2(PRESCALE);
   localparam int IW = (DIGITS > 1) ? clog2(DIGITS) : 1;
   localparam logic SAL = (SEG_ACTIVE_LOW != 0);
   localparam logic DAL = (DIG_ACTIVE_LOW != 0);

   logic [PW-1:0]         ps;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   stg_val;
   logic [DIGITS-1:0]     stg_dp;
   logic [4*DIGITS-1:0]   disp_val;
   logic [DIGITS-1:0]     disp_dp;
   logic                  pending;
   logic                  fd_r;
   logic [6:0]            seg_r;
   logic                  dp_r;
   logic [DIGITS-1:0]     dig_r;

   logic                  tick;
   logic                  last;
   logic                  boundary;
   logic                  apply;
   logic [4*DIGITS-1:0]   vsh;
   logic [DIGITS-1:0]     dsh;
   logic [DIGITS-1:0]     bsh;
   logic [DIGITS-1:0]     blank;
   logic [DIGITS-1:0]     onehot;
   logic [3:0]            nib;
   logic [6:0]            hex_seg;
   logic                  zeros;

   assign tick     = bus.enable && (ps == PW'(PRESCALE - 1));
   assign last     = (idx == IW'(DIGITS - 1));
   assign boundary = tick && last;
   // While off there is no scan to tear, so staged data goes straight in.
   assign apply    = pending && (boundary || !bus.enable);

   assign vsh    = disp_val >> {idx, 2'b00};
   assign dsh    = disp_dp >> idx;
   assign bsh    = blank >> idx;
   assign nib    = vsh[3:0];
   assign onehot = DIGITS'(1) << idx;

   // Digit i blanks when it and all higher nibbles are zero; digit 0 never.
   always_comb begin
      blank = '0;
      zeros = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zeros = zeros && (disp_val[4*i +: 4] == 4'h0);
         if (i > 0)
            blank[i] = zeros && bus.blank_lz;
      end
   end

   hex_to_seg7 u_hex (
      .nibble (nib),
      .seg    (hex_seg)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ps       <= '0;
         idx      <= '0;
         stg_val  <= '0;
         stg_dp   <= '0;
         disp_val <= '0;
         disp_dp  <= '0;
         pending  <= 1'b0;
         fd_r     <= 1'b0;
         seg_r    <= '0;
         dp_r     <= 1'b0;
         dig_r    <= '0;
      end else begin
         fd_r <= boundary;

         if (!bus.enable) begin
            ps  <= '0;
            idx <= '0;
         end else if (tick) begin
            ps  <= '0;
            idx <= last ? '0 : idx + IW'(1);
         end else begin
            ps  <= ps + PW'(1);
         end

         if (apply) begin
            disp_val <= stg_val;
            disp_dp  <= stg_dp;
         end

         // A load coinciding with apply stays pending for the next frame.
         if (bus.load) begin
            stg_val <= bus.value;
            stg_dp  <= bus.dp;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end

         if (bus.enable) begin
            seg_r <= bsh[0] ? 7'd0 : hex_seg;
            dp_r  <= dsh[0];
            dig_r <= onehot;
         end else begin
            seg_r <= '0;
            dp_r  <= 1'b0;
            dig_r <= '0;
         end
      end
   end

   // Pin polarity is applied after the registers only.
   assign bus.seg        = seg_r ^ {7{SAL}};
   assign bus.seg_dp     = dp_r ^ SAL;
   assign bus.digit_en   = dig_r ^ {DIGITS{DAL}};
   assign bus.frame_done = fd_r;

endmodule
